mem_arbiter_n: RTL
==================

Name: mem_arbiter_n

Overview:
- N-port, parametrised arbiter between cache-line requesters and the single external memory port.
- Generalises the current fixed three-client arbiter (Icache read, Dcache read, Dcache write) to N_PORTS clients, configurable widths, and selectable round-robin or fixed priority.
- Serves one memory transaction at a time. The grant is held until the memory acknowledges, then one response cycle is returned to the winning port.

Parameters:
- N_PORTS, 3, number of requesting clients (2..8).
- ADDR_W, 32, address width.
- DATA_W, 128, memory data/line width.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest).
- TIMEOUT_CYCLES, 255, watchdog limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_PORTS  per-port request, level; held until ack.
- rw  in  N_PORTS  per-port direction, 1 = write, 0 = read.
- addr  in  N_PORTS*ADDR_W  per-port address, flattened, port i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_PORTS*DATA_W  per-port write data, flattened.
- ack  out  N_PORTS  one-cycle completion pulse, one-hot or zero.
- rdata  out  DATA_W  read data, shared bus, valid while ack is non-zero.
- mem_enable  out  1  memory request.
- mem_rw  out  1  memory direction.
- mem_ack  in  1  memory completion.
- mem_addr  out  ADDR_W  memory address.
- mem_data_out  in  DATA_W  data from memory.
- mem_data_in  out  DATA_W  data to memory.
- err  out  N_PORTS  timeout pulse; present only with MEM_ARB_TIMEOUT_EN.

Behaviour:
- Reset state: IDLE. ack=0, rdata=0, mem_enable=0, mem_rw=0, mem_addr=0, mem_data_in=0, err=0. Round-robin pointer last=N_PORTS-1, so port 0 is first in line.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If req != 0, select winner g. In round-robin mode, g is the first set bit scanning last+1 .. last+N_PORTS (mod N_PORTS). In fixed mode, g is the lowest set index.
  - Latch rw[g], addr[g], wdata[g] and g into registers, then go to BUSY.
  - mem_enable rises on the edge leaving IDLE, so arbitration latency is 1 cycle.
- BUSY:
  - mem_enable=1. mem_rw, mem_addr and mem_data_in are driven from latched values and are stable for the whole transaction. Later changes on a requester's inputs have no effect.
  - On mem_ack=1: capture mem_data_out into rdata (for reads; for writes rdata keeps its previous value), set ack[g]=1, drop mem_enable, go to RESP.
- RESP:
  - ack[g]=1 for exactly this one cycle.
  - In round-robin mode set last=g. Go to IDLE; ack returns to 0.
- Requester contract: drop req on the edge where it sees ack. A req still high in the following IDLE cycle is treated as a new request.
- mem_ack outside BUSY is ignored.
- Simultaneous requests: exactly one grant per transaction. The others wait with no pulse.
- Round-robin guarantees each requester is served within N_PORTS transactions. Fixed mode may starve high indices; that is accepted.
- Minimum transaction is 3 cycles: IDLE, BUSY with ack in the same cycle, RESP.
- Reset asserted mid-transaction: immediate return to IDLE, all outputs to reset values, pointer reset. The in-flight memory access is abandoned without an ack.
- Port index and pointer width is clog2(N_PORTS), minimum 1.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES with no mem_ack: mem_enable drops, and ack[g] and err[g] pulse together in RESP. rdata is unchanged.
  - mem_ack arriving in the same cycle as expiry wins, and no err is raised.
- Undefined: BUSY waits indefinitely, the err port does not exist, and there is no counter logic.

Decomposition:
- Shared package/header holds:
  - state encodings ARB_IDLE, ARB_BUSY, ARB_RESP;
  - PRIO_RR and PRIO_FIXED constants;
  - the clog2 helper function.
- One natural sub-module, arb_prio_select: combinational. Inputs are the req vector, last pointer and mode; outputs are the winner index and a valid flag. Unit-tested on its own.

Test Plan:
- Single read: port 1 requests a read of 0x0000_0040 while memory asserts mem_ack 4 cycles after mem_enable with data 0xA5..A5.
  - Expected: mem_addr=0x40, mem_rw=0.
  - Expected: ack=3'b010 for one cycle, rdata=0xA5..A5.
- Simultaneous requests, round-robin: req=3'b111 held with re-request after each ack.
  - Expected: grant order 0, 1, 2, 0.
  - Expected: no two ack bits ever high together.
- Simultaneous requests, fixed priority (PRIO_MODE=1): req=3'b110.
  - Expected: port 1 granted first.
  - If port 1 re-requests every time, port 2 is never served within a 10-transaction window.
- Write latch stability: port 2 writes 0x1234 to address 0x80, then changes addr/wdata during BUSY.
  - Expected: mem_addr and mem_data_in stay 0x80 and 0x1234 until mem_ack.
  - Expected: mem_rw=1 throughout.
- Reset mid-BUSY: assert reset 2 cycles into BUSY.
  - Expected: mem_enable=0 immediately, ack never pulses.
  - Expected: next req=3'b100 is granted to port 2 normally.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): mem_ack held low.
  - Expected: ack and err pulse on the granted port after 8 BUSY cycles.
  - Expected: mem_enable=0 afterwards.

Source files
------------

// File: rtl/mem_arbiter_n_pkg.sv
// Shared encodings and helpers for the N-port memory arbiter.
// Arbiter FSM states, priority-mode constants and index-width helper.
package mem_arbiter_n_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // Index width for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arbiter_n_if.sv
// Requester-side and memory-side signals of the N-port arbiter; master is the arbiter's view.
// The err vector exists only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_arbiter_n_if #(
    parameter int N_PORTS = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128
);
    logic [N_PORTS-1:0]        req;
    logic [N_PORTS-1:0]        rw;
    logic [N_PORTS*ADDR_W-1:0] addr;
    logic [N_PORTS*DATA_W-1:0] wdata;
    logic [N_PORTS-1:0]        ack;
    logic [DATA_W-1:0]         rdata;

    logic                      mem_enable;
    logic                      mem_rw;
    logic                      mem_ack;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_data_out;
    logic [DATA_W-1:0]         mem_data_in;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [N_PORTS-1:0]        err;
`endif

    modport master (
        input  req, rw, addr, wdata, mem_ack, mem_data_out,
        output ack, rdata, mem_enable, mem_rw, mem_addr, mem_data_in
`ifdef MEM_ARB_TIMEOUT_EN
        , output err
`endif
    );

    modport slave (
        output req, rw, addr, wdata, mem_ack, mem_data_out,
        input  ack, rdata, mem_enable, mem_rw, mem_addr, mem_data_in
`ifdef MEM_ARB_TIMEOUT_EN
        , input err
`endif
    );

endinterface

// File: rtl/mem_arbiter_n_arb_prio_select.sv
// Combinational winner pick: round-robin starting after last_i, or lowest index in fixed mode.
// Zero latency; gnt_vld_o is low when no request is pending.
module arb_prio_select
    import mem_arbiter_n_pkg::*;
#(
    parameter int N_PORTS = 3,
    parameter int IDX_W   = 2
) (
    input  logic [N_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    input  logic               mode_i,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_vld_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        if (int'(mode_i) == PRIO_FIXED) begin
            // Scan downward so the lowest requesting index is the last one written.
            for (int i = N_PORTS - 1; i >= 0; i--) begin
                idx = IDX_W'(i);
                if (req_i[idx]) begin
                    gnt_idx_o = idx;
                    gnt_vld_o = 1'b1;
                end
            end
        end else begin
            // Offset N_PORTS is last_i itself: lowest priority, overwritten by any nearer one.
            for (int k = N_PORTS; k >= 1; k--) begin
                idx = IDX_W'((int'(last_i) + k) % N_PORTS);
                if (req_i[idx]) begin
                    gnt_idx_o = idx;
                    gnt_vld_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-port arbiter onto one memory port: 1-cycle arbitration, grant held until mem_ack, one ack cycle.
// Requesters stall (hold req) until acked; MEM_ARB_TIMEOUT_EN adds a BUSY watchdog with err pulse.
module mem_arbiter_n
    import mem_arbiter_n_pkg::*;
#(
    parameter int N_PORTS        = 3,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 128,
    parameter int PRIO_MODE      = PRIO_RR,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    mem_arbiter_n_if.master bus
);

    localparam int IDX_W = clog2_min1(N_PORTS);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               to_q, to_d;
`endif

    logic [ADDR_W-1:0]  addr_arr  [N_PORTS];
    logic [DATA_W-1:0]  wdata_arr [N_PORTS];
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_vld;
    logic [N_PORTS-1:0] gnt_oh;

    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            addr_arr[i]  = bus.addr[i*ADDR_W +: ADDR_W];
            wdata_arr[i] = bus.wdata[i*DATA_W +: DATA_W];
        end
    end

    arb_prio_select #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_prio_select (
        .req_i     (bus.req),
        .last_i    (last_q),
        .mode_i    (PRIO_MODE == PRIO_FIXED),
        .gnt_idx_o (sel_idx),
        .gnt_vld_o (sel_vld)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = to_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (sel_vld) begin
                    gnt_d   = sel_idx;
                    rw_d    = bus.rw[sel_idx];
                    addr_d  = addr_arr[sel_idx];
                    wdata_d = wdata_arr[sel_idx];
                    state_d = ARB_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                    to_d    = 1'b0;
`endif
                end
            end
            ARB_BUSY: begin
                // mem_ack is checked first so it beats a simultaneous watchdog expiry.
                if (bus.mem_ack) begin
                    if (!rw_q) begin
                        rdata_d = bus.mem_data_out;
                    end
                    state_d = ARB_RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    to_d    = 1'b1;
                    state_d = ARB_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ARB_RESP: begin
                if (PRIO_MODE == PRIO_RR) begin
                    last_d = gnt_q;
                end
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            last_q  <= IDX_W'(N_PORTS - 1);
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign gnt_oh          = {{(N_PORTS-1){1'b0}}, 1'b1} << gnt_q;
    assign bus.ack         = (state_q == ARB_RESP) ? gnt_oh : '0;
    assign bus.rdata       = rdata_q;
    assign bus.mem_enable  = (state_q == ARB_BUSY);
    assign bus.mem_rw      = rw_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_data_in = wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.err         = (state_q == ARB_RESP && to_q) ? gnt_oh : '0;
`endif

endmodule
